// File: rtl/stage12_fifo_ctrl.sv
// Frame-level sequencer for the 12-stage layer-3 weight delay line.
// It accepts a frame of words over valid/ready and writes each accepted word
// into the free-running delay line. On cycles with no accepted word it writes
// a zero bubble. A tag shift register marks which delay-line slots hold real
// words. The controller uses the tags to qualify the delay-line output,
// index it within the frame, and signal end of frame once the line drains.
module stage12_fifo_ctrl #(
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] fifo_in,
  input  logic [DATA_W-1:0] fifo_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DEPTH-1:0]   tag;
  logic [CNT_W-1:0]   acc_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_m1;
  logic               push;
  logic               start_acc;

  assign len_m1 = len_q - CNT_W'(1);

  // Handshake, delay-line write data and output qualification.
  always_comb begin
    in_ready  = (state == S_RUN) && (acc_cnt < len_q);
    push      = in_valid && in_ready;
    fifo_in   = push ? in_data : '0;
    out_valid = tag[DEPTH-1];
    out_data  = fifo_out;
    out_idx   = out_cnt;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    start_acc = (state == S_IDLE) && start;
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (frame_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push && (acc_cnt == len_m1)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid && (out_cnt == len_m1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Tag register shifts in lockstep with the delay line; it is 1 where a real word sits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag <= '0;
    end else begin
      tag <= {tag[DEPTH-2:0], push};
    end
  end

  // Frame length latch and the accept/emit counters. Both counters restart on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      acc_cnt <= '0;
      out_cnt <= '0;
    end else if (start_acc) begin
      len_q   <= frame_len;
      acc_cnt <= '0;
      out_cnt <= '0;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (out_valid) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

endmodule
